// File: rtl/ctrl_pkg.sv
// Shared opcode values, sequencer state encoding and bus-select helpers.
package ctrl_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NAN = 3'b010;
    localparam logic [2:0] OP_HLT = 3'b011;
    localparam logic [2:0] OP_OUT = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;
    localparam logic [2:0] OP_BNE = 3'b110;
    localparam logic [2:0] OP_REP = 3'b111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_OP1    = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    // First state after FETCH, chosen by the opcode being accepted.
    function automatic state_t fetch_next(input logic [2:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_NAN: return ST_OP1;
            OP_REP, OP_LDI:         return ST_EXEC;
            OP_OUT, OP_BNE:         return ST_WB;
            default:                return ST_HALTED;
        endcase
    endfunction

    // Debug step code; HALTED shares the WB code.
    function automatic logic [1:0] step_code(input state_t s);
        case (s)
            ST_FETCH: return 2'b00;
            ST_OP1:   return 2'b01;
            ST_EXEC:  return 2'b10;
            default:  return 2'b11;
        endcase
    endfunction

    // Bus-mux code of the immediate, just above the register codes.
    function automatic int unsigned sel_imm(input int unsigned nreg);
        return nreg;
    endfunction

    // Bus-mux code of the R register.
    function automatic int unsigned sel_r(input int unsigned nreg);
        return nreg + 1;
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Register-index to one-hot write-enable decoder with a global enable.
module onehot_dec #(
    parameter int RSEL_W = 3
) (
    input  logic [RSEL_W-1:0]      sel,
    input  logic                   en,
    output logic [(1<<RSEL_W)-1:0] onehot
);

    // Single bit set at the selected index when enabled.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Self-sequencing processor control unit: fetch handshake, per-opcode step
// FSM, stall, sticky halt and a saturating retired-instruction counter.
//
// state   | meaning
// FETCH   | waiting for a valid instruction (step 00)
// OP1     | load A from RX, ALU ops only (step 01)
// EXEC    | ALU/REP/LDI result into R (step 10)
// WB      | write back / OUT / BNE, advance PC, retire (step 11)
// HALTED  | sticky stop after HLT, left only by reset (step 11)
module ctrl_sequencer #(
    parameter int DATA_W      = 16,
    parameter int NREG        = 8,
    parameter int RSEL_W      = $clog2(NREG),
    parameter int INSTR_W     = 16,
    parameter int SEL_W       = $clog2(NREG + 2),
    parameter int CNT_W       = 16,
    parameter bit BNE_ON_ZERO = 1'b1
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic               hold,
    input  logic [DATA_W-1:0]  mux_out,
    output logic [2:0]         OpSelect,
    output logic [NREG-1:0]    reg_enable,
    output logic               A_enable,
    output logic               R_enable,
    output logic [SEL_W-1:0]   selReg,
    output logic               bus_enable,
    output logic               pc_enable,
    output logic               pc_load,
    output logic               halt,
    output logic [1:0]         step,
    output logic [CNT_W-1:0]   retired
);

    import ctrl_pkg::*;

    // Only opcode, RX and RY are ever decoded, so only they are latched.
    localparam int IR_W = 3 + 2 * RSEL_W;
    localparam logic [SEL_W-1:0] SEL_IMM_C = SEL_W'(sel_imm(NREG));
    localparam logic [SEL_W-1:0] SEL_R_C   = SEL_W'(sel_r(NREG));

    state_t            state;
    logic [IR_W-1:0]   ir;
    logic [2:0]        op;
    logic [RSEL_W-1:0] rx;
    logic [RSEL_W-1:0] ry;
    logic              wb_we;

    assign op = ir[IR_W-1 -: 3];
    assign rx = ir[IR_W-4 -: RSEL_W];
    assign ry = ir[IR_W-4-RSEL_W -: RSEL_W];

    generate
        if (INSTR_W > IR_W) begin : g_spare
            logic unused_instr_bits;
            assign unused_instr_bits = ^instr[INSTR_W-IR_W-1:0];
        end
    endgenerate

    // Step FSM, instruction latch and retired counter; hold freezes all of it
    // except in HALTED, which only reset can leave.
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            state   <= ST_FETCH;
            ir      <= '0;
            retired <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (!hold && instr_valid) begin
                        ir    <= instr[INSTR_W-1 -: IR_W];
                        state <= fetch_next(instr[INSTR_W-1 -: 3]);
                    end
                end
                ST_OP1: begin
                    if (!hold) state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (!hold) state <= ST_WB;
                end
                ST_WB: begin
                    if (!hold) begin
                        state <= ST_FETCH;
                        if (retired != '1) begin
                            retired <= retired + CNT_W'(1);
                        end
                    end
                end
                ST_HALTED: state <= ST_HALTED;
                default:   state <= ST_FETCH;
            endcase
        end
    end

    // Datapath controls decoded from state and the latched instruction;
    // hold gates every enable but leaves the selects alone.
    always_comb begin
        instr_ready = 1'b0;
        OpSelect    = 3'b000;
        A_enable    = 1'b0;
        R_enable    = 1'b0;
        selReg      = '0;
        bus_enable  = 1'b0;
        pc_enable   = 1'b0;
        pc_load     = 1'b0;
        halt        = 1'b0;
        wb_we       = 1'b0;
        step        = step_code(state);
        case (state)
            ST_FETCH: begin
                instr_ready = !hold;
            end
            ST_OP1: begin
                selReg   = SEL_W'(rx);
                A_enable = !hold;
            end
            ST_EXEC: begin
                R_enable = !hold;
                if (op == OP_LDI) begin
                    selReg   = SEL_IMM_C;
                    OpSelect = OP_REP;
                end else begin
                    selReg   = SEL_W'(ry);
                    OpSelect = op;
                end
            end
            ST_WB: begin
                pc_enable = !hold;
                case (op)
                    OP_OUT: begin
                        selReg     = SEL_W'(rx);
                        bus_enable = !hold;
                    end
                    OP_BNE: begin
                        selReg  = SEL_W'(rx);
                        pc_load = BNE_ON_ZERO ? (mux_out == '0) : (mux_out != '0);
                    end
                    default: begin
                        selReg = SEL_R_C;
                        wb_we  = !hold;
                    end
                endcase
            end
            ST_HALTED: begin
                halt = 1'b1;
            end
            default: ;
        endcase
    end

    onehot_dec #(
        .RSEL_W (RSEL_W)
    ) u_wb_dec (
        .sel    (rx),
        .en     (wb_we),
        .onehot (reg_enable)
    );

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: two builds (default, and inverted BNE with a
// 4-bit counter) share one stimulus stream and are compared each cycle
// against an instruction-level reference model.
module tb_ctrl_sequencer;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, NAN = 3'b010, HLT = 3'b011;
    localparam logic [2:0] OUT = 3'b100, LDI = 3'b101, BNE = 3'b110, REP = 3'b111;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        hold = 1'b0;
    logic [15:0] mux_out = '0;

    logic       a_ready, a_aen, a_ren, a_bus, a_pce, a_pcl, a_halt;
    logic [2:0] a_ops;
    logic [7:0] a_reg;
    logic [3:0] a_sel;
    logic [1:0] a_step;
    logic [15:0] a_ret;

    logic       b_ready, b_aen, b_ren, b_bus, b_pce, b_pcl, b_halt;
    logic [2:0] b_ops;
    logic [7:0] b_reg;
    logic [3:0] b_sel;
    logic [1:0] b_step;
    logic [3:0] b_ret;

    int n_checks = 0;
    int n_fail = 0;

    // reference model: instruction-level progress
    int         m_beat = 0;
    logic [2:0] m_op = 3'b000, m_rx = 3'b000, m_ry = 3'b000;
    bit         m_halted = 1'b0;
    int         m_ret = 0;

    int n_sat = 0, n_mid_reset = 0, n_halt_cyc = 0, n_hold_busy = 0, n_bne_taken = 0;

    always #5 clock = ~clock;

    ctrl_sequencer u_dut_a (
        .clock(clock), .resetn(resetn), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(a_ready), .hold(hold), .mux_out(mux_out), .OpSelect(a_ops),
        .reg_enable(a_reg), .A_enable(a_aen), .R_enable(a_ren), .selReg(a_sel),
        .bus_enable(a_bus), .pc_enable(a_pce), .pc_load(a_pcl), .halt(a_halt),
        .step(a_step), .retired(a_ret)
    );

    ctrl_sequencer #(.CNT_W(4), .BNE_ON_ZERO(1'b0)) u_dut_b (
        .clock(clock), .resetn(resetn), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(b_ready), .hold(hold), .mux_out(mux_out), .OpSelect(b_ops),
        .reg_enable(b_reg), .A_enable(b_aen), .R_enable(b_ren), .selReg(b_sel),
        .bus_enable(b_bus), .pc_enable(b_pce), .pc_load(b_pcl), .halt(b_halt),
        .step(b_step), .retired(b_ret)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int cpi(input logic [2:0] op);
        case (op)
            ADD, SUB, NAN: return 4;
            REP, LDI:      return 3;
            default:       return 2;
        endcase
    endfunction

    // phase 0=fetch 1=operand 2=execute 3=writeback; short ops skip early phases
    function automatic int phase_of(input logic [2:0] op, input int beat);
        if (beat == 0) return 0;
        return 4 - cpi(op) + beat;
    endfunction

    task automatic check_all();
        int ph;
        logic e_ready, e_aen, e_ren, e_bus, e_pce, e_pcl_a, e_pcl_b, e_halt;
        logic [2:0] e_ops;
        logic [7:0] e_reg;
        logic [3:0] e_sel;
        logic [1:0] e_step;
        e_ready = 0; e_aen = 0; e_ren = 0; e_bus = 0; e_pce = 0;
        e_pcl_a = 0; e_pcl_b = 0; e_halt = 0; e_ops = 0; e_reg = 0; e_sel = 0;
        if (m_halted) begin
            e_halt = 1;
            e_step = 2'b11;
        end else begin
            ph = phase_of(m_op, m_beat);
            e_step = 2'(ph);
            case (ph)
                0: e_ready = !hold;
                1: begin
                    e_sel = {1'b0, m_rx};
                    e_aen = !hold;
                end
                2: begin
                    e_ren = !hold;
                    e_sel = (m_op == LDI) ? 4'd8 : {1'b0, m_ry};
                    e_ops = (m_op == LDI) ? REP : m_op;
                end
                default: begin
                    e_pce = !hold;
                    if (m_op == OUT) begin
                        e_sel = {1'b0, m_rx};
                        e_bus = !hold;
                    end else if (m_op == BNE) begin
                        e_sel = {1'b0, m_rx};
                        e_pcl_a = (mux_out == 0);
                        e_pcl_b = (mux_out != 0);
                    end else begin
                        e_sel = 4'd9;
                        e_reg = hold ? 8'h00 : (8'b1 << m_rx);
                    end
                end
            endcase
        end
        check_eq("ready_a", a_ready, e_ready);  check_eq("ready_b", b_ready, e_ready);
        check_eq("opsel_a", a_ops, e_ops);      check_eq("opsel_b", b_ops, e_ops);
        check_eq("regen_a", a_reg, e_reg);      check_eq("regen_b", b_reg, e_reg);
        check_eq("aen_a", a_aen, e_aen);        check_eq("aen_b", b_aen, e_aen);
        check_eq("ren_a", a_ren, e_ren);        check_eq("ren_b", b_ren, e_ren);
        check_eq("sel_a", a_sel, e_sel);        check_eq("sel_b", b_sel, e_sel);
        check_eq("bus_a", a_bus, e_bus);        check_eq("bus_b", b_bus, e_bus);
        check_eq("pce_a", a_pce, e_pce);        check_eq("pce_b", b_pce, e_pce);
        check_eq("pcl_a", a_pcl, e_pcl_a);      check_eq("pcl_b", b_pcl, e_pcl_b);
        check_eq("halt_a", a_halt, e_halt);     check_eq("halt_b", b_halt, e_halt);
        check_eq("step_a", a_step, e_step);     check_eq("step_b", b_step, e_step);
        check_eq("ret_a", a_ret, (m_ret > 65535) ? 65535 : m_ret);
        check_eq("ret_b", b_ret, (m_ret > 15) ? 15 : m_ret);
    endtask

    task automatic model_reset();
        m_beat = 0; m_op = 0; m_rx = 0; m_ry = 0; m_halted = 0; m_ret = 0;
    endtask

    task automatic model_step();
        if (m_halted) begin
            n_halt_cyc++;
        end else if (hold) begin
            if (m_beat != 0) n_hold_busy++;
        end else if (m_beat == 0) begin
            if (instr_valid) begin
                m_op = instr[15:13];
                m_rx = instr[12:10];
                m_ry = instr[9:7];
                if (m_op == HLT) m_halted = 1;
                else m_beat = 1;
            end
        end else if (m_beat == cpi(m_op) - 1) begin
            if (m_op == BNE && mux_out == 0) n_bne_taken++;
            if (m_ret >= 15) n_sat++;
            m_ret++;
            m_beat = 0;
        end else begin
            m_beat++;
        end
    endtask

    // one clock: drive after the falling edge, check, optionally reset mid-cycle
    task automatic run_cycle(input logic v, input logic [15:0] ins, input logic h,
                             input logic [15:0] mx, input bit rst);
        @(negedge clock);
        if (resetn) resetn = 1'b0;
        instr_valid = v;
        instr = ins;
        hold = h;
        mux_out = mx;
        #1;
        check_all();
        if (rst) begin
            #1;
            resetn = 1'b1;
            hold = 1'b0;
            #1;
            if (!m_halted && m_beat != 0) n_mid_reset++;
            model_reset();
            check_all();
        end else begin
            model_step();
        end
    endtask

    function automatic logic [15:0] rand_instr();
        logic [2:0] op;
        logic [15:0] w;
        w = 16'($urandom);
        if ($urandom_range(0, 99) < 2) op = HLT;
        else begin
            op = 3'($urandom_range(0, 6));
            if (op == HLT) op = REP;
        end
        return {op, w[12:0]};
    endfunction

    initial begin
        resetn = 1'b0;
        #1 resetn = 1'b1;
        model_reset();
        #1 check_all();

        // ADD R1,R2 / LDI R3 / OUT R5
        run_cycle(1, 16'h0500, 0, 0, 0);
        repeat (3) run_cycle(0, 16'h0000, 0, 0, 0);
        run_cycle(1, 16'hAC00, 0, 0, 0);
        repeat (2) run_cycle(0, 16'h0000, 0, 0, 0);
        run_cycle(1, 16'h9400, 0, 0, 0);
        run_cycle(0, 16'h0000, 0, 0, 0);
        // BNE R0 with zero and nonzero bus
        run_cycle(1, 16'hC000, 0, 0, 0);
        run_cycle(0, 16'h0000, 0, 16'h0000, 0);
        run_cycle(1, 16'hC000, 0, 0, 0);
        run_cycle(0, 16'h0000, 0, 16'h0004, 0);
        // SUB R4,R6 with a three-cycle stall in EXEC
        run_cycle(1, 16'h3300, 0, 0, 0);
        run_cycle(0, 16'h0000, 0, 0, 0);
        repeat (3) run_cycle(0, 16'h0000, 1, 0, 0);
        repeat (2) run_cycle(0, 16'h0000, 0, 0, 0);
        // NAN R2,R7 reset while in OP1
        run_cycle(1, 16'h4B80, 0, 0, 0);
        run_cycle(0, 16'h0000, 0, 0, 1);
        // HLT, then valid instructions with toggling hold, then reset
        run_cycle(1, 16'h6000, 0, 0, 0);
        for (int i = 0; i < 10; i++) run_cycle(1, 16'h0500, 1'(i % 2), 0, 0);
        run_cycle(1, 16'h0500, 0, 0, 1);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            logic v, h;
            logic [15:0] mx;
            bit r;
            v  = ($urandom_range(0, 3) != 0);
            h  = ($urandom_range(0, 4) == 0);
            mx = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
            r  = m_halted ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 299) == 0);
            run_cycle(v, rand_instr(), h, mx, r);
        end

        check_eq("cov_sat", 32'(n_sat > 0), 1);
        check_eq("cov_mid_reset", 32'(n_mid_reset > 0), 1);
        check_eq("cov_halt", 32'(n_halt_cyc > 0), 1);
        check_eq("cov_hold_busy", 32'(n_hold_busy > 0), 1);
        check_eq("cov_bne_taken", 32'(n_bne_taken > 0), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Parametrised, self-sequencing successor to the processor's combinational control unit.
- Owns its own step FSM, replacing the external 2-bit step counter, and fetches through a valid/ready handshake.
- Runs each opcode in a variable number of cycles and supports a stall input.
- Latches HALT stickily, counts retired instructions, and makes branch polarity a parameter.
- Sits between instruction memory/PC and the register file, ALU, A/R registers and bus mux.

Parameters:
- DATA_W, 16, width of the bus value (mux_out) tested by BNE.
- NREG, 8, number of general registers; must be a power of 2, at least 2.
- RSEL_W, $clog2(NREG), register-index field width.
- INSTR_W, 16, instruction width; must be at least 3+2*RSEL_W.
- SEL_W, $clog2(NREG+2), bus-mux select width. Code NREG selects the immediate; code NREG+1 selects R.
- CNT_W, 16, retired-instruction counter width.
- BNE_ON_ZERO, 1. If 1, BNE loads the PC when the tested value is 0; if 0, it loads when the value is nonzero.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-high reset (1 = reset).
- instr  in  INSTR_W  instruction word. Fields: opcode=[INSTR_W-1 -: 3], RX=next RSEL_W bits, RY=next RSEL_W bits.
- instr_valid  in  1  instr is valid.
- instr_ready  out  1  sequencer accepts instr this cycle.
- hold  in  1  stall; the FSM freezes.
- mux_out  in  DATA_W  current bus value, used for the BNE test.
- OpSelect  out  3  ALU operation.
- reg_enable  out  NREG  one-hot register write enable.
- A_enable  out  1  write A register.
- R_enable  out  1  write R register.
- selReg  out  SEL_W  bus-mux select.
- bus_enable  out  1  drive the output bus (OUT).
- pc_enable  out  1  update PC this cycle.
- pc_load  out  1  1 = load branch target, 0 = increment.
- halt  out  1  processor halted.
- step  out  2  current state encoding, for debug.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Opcodes are fixed in a shared package: ADD=000, SUB=001, NAN=010, HLT=011, OUT=100, LDI=101, BNE=110, REP=111.
- States and step encodings: FETCH=00, OP1=01, EXEC=10, WB=11, plus HALTED (step=11).
- On reset:
  - state=FETCH; the instruction latch is cleared; retired=0.
  - All outputs are 0 except instr_ready=1.
- FETCH:
  - instr_ready=1 while hold=0.
  - On instr_valid&&instr_ready the instruction is latched and the next state is taken from its opcode:
    - ADD/SUB/NAN go to OP1.
    - REP/LDI go to EXEC.
    - OUT/BNE go to WB.
    - HLT goes to HALTED.
  - Without a valid handshake the state stays FETCH.
- Every decode uses the latched instruction, never the live instr.
- OP1: selReg=RX, A_enable=1. Next state EXEC.
- EXEC:
  - ADD/SUB/NAN: selReg=RY, OpSelect=opcode, R_enable=1.
  - REP: selReg=RY, OpSelect=REP, R_enable=1.
  - LDI: selReg=NREG, OpSelect=REP, R_enable=1.
  - Next state WB.
- WB, then next state FETCH:
  - ADD/SUB/NAN/REP/LDI: reg_enable=onehot(RX), selReg=NREG+1, pc_enable=1, pc_load=0.
  - OUT: selReg=RX, bus_enable=1, pc_enable=1, pc_load=0.
  - BNE: selReg=RX, pc_enable=1. pc_load=(mux_out==0) when BNE_ON_ZERO=1, else pc_load=(mux_out!=0).
- Cycles per instruction, including FETCH:
  - ADD/SUB/NAN: 4.
  - REP/LDI: 3.
  - OUT/BNE: 2.
- Output timing: outputs are combinational from state and latched instruction. mux_out is sampled combinationally in WB.
- hold=1:
  - The state is frozen and instr_ready=0.
  - reg_enable, A_enable, R_enable, bus_enable, pc_enable and retired increment are all forced to 0.
  - selReg and OpSelect keep their state-derived values.
- retired increments by 1 on each WB cycle with hold=0. It saturates at all-ones and does not wrap.
- HALTED:
  - halt=1; all enables are 0; instr_ready=0.
  - The state is sticky: it is left only by reset. hold is ignored.
- Reset asserted in any state, including mid-instruction, returns to FETCH immediately (asynchronously). No write enable may glitch high during reset.
- RX/RY indices are always in range because NREG is a power of 2.

Decomposition:
- ctrl_pkg holds the opcode localparams, the state enum/encodings, and the SEL_IMM/SEL_R helper functions of NREG.
- One sub-module, onehot_dec, parametrised by RSEL_W, generalises the existing register decoder.

Test Plan:
- Reset, then ADD R1,R2 (NREG=8): state sequence FETCH, OP1, EXEC, WB.
  - OP1: A_enable=1, selReg=1.
  - EXEC: selReg=2, OpSelect=000, R_enable=1.
  - WB: reg_enable=8'b00000010, selReg=9, pc_enable=1. retired becomes 1.
- LDI R3: 3 cycles. EXEC has selReg=8 and OpSelect=111; WB has reg_enable=8'b00001000.
  - Then OUT R5: 2 cycles; WB has bus_enable=1, selReg=5.
- BNE R0 with mux_out=0: pc_load=1. With mux_out=16'h0004: pc_load=0.
  - Rerun with BNE_ON_ZERO=0 and check the polarity inverts.
- HLT: halt=1 from the cycle after acceptance. It persists for 10 cycles with instr_valid=1 and hold toggling; instr_ready=0 and retired is unchanged.
  - resetn=1 clears halt.
- hold=1 for 3 cycles during the EXEC of SUB: step stays 10, R_enable=0, selReg is held at RY.
  - After release, the instruction completes with the correct WB.
- Reset asserted in OP1 of NAN: all enables drop to 0 without waiting for a clock edge, and step=00.
  - Set retired to all-ones (CNT_W=4 build) and retire one more instruction: retired stays at 4'hF.
